// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch/issue front end.
//   OPCODE_W      width of the opcode field at the top of an instruction word
//   OPCODE_HALT   opcode that stops fetching (only acted on with FETCH_HALT_EN)
//   fetch_state_t fetch FSM state type, with the FETCH/ISSUE/HALT encodings
package cpu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OPCODE_HALT = 4'b1111;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_ISSUE = 2'd1;
  localparam fetch_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/fetch_issue_if.sv
// fetch_issue_if: groups the instruction-memory read bus and the issue
// handshake toward the controlUnit/datapath.
//   master modport: fetch unit side (drives imem_req/imem_addr and the issue
//                   outputs, receives imem_ack/imem_rdata, issue_ready,
//                   ni and branch_target)
//   slave modport : memory + consumer side (the opposite directions)
interface fetch_issue_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  logic                issue_valid;
  logic                issue_ready;
  logic [INSTR_W-1:0]  instr_out;
  logic [OPCODE_W-1:0] opCode;
  logic [PC_W-1:0]     pc_out;
  logic                ni;
  logic [PC_W-1:0]     branch_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output issue_valid, instr_out, opCode, pc_out,
    input  issue_ready, ni, branch_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  issue_valid, instr_out, opCode, pc_out,
    output issue_ready, ni, branch_target
  );

endinterface

// File: rtl/flag_reg.sv
// flag_reg: N/Z condition-flag register with a write enable.
//   clk, rst_n   clock and asynchronous active-low reset (flags clear to 0)
//   we           load strobe; n_in/z_in captured on rising clk when set
//   n_q, z_q     registered flags
module flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic n_in,
  input  logic z_in,
  output logic n_q,
  output logic z_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (we) begin
      n_q <= n_in;
      z_q <= z_in;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// fetch_issue: instruction fetch and single-entry issue stage.
// Fetches the word at PC, holds it on the issue port until the consumer
// accepts it, then advances PC (sequential or taken branch) and fetches again.
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (master)        imem read bus + issue handshake (see fetch_issue_if)
//   flagN, flagZ        registered ALU flags for the controlUnit
//   alu_flag_we,
//   alu_n, alu_z        flag update strobe and values
//   halted              fetch stopped on a HALT opcode (FETCH_HALT_EN only)
// Build option: define FETCH_HALT_EN to enable the HALT opcode / halted port.
module fetch_issue
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_issue_if.master bus,
  output logic          flagN,
  output logic          flagZ,
  input  logic          alu_flag_we,
  input  logic          alu_n,
  input  logic          alu_z
`ifdef FETCH_HALT_EN
  ,
  output logic          halted
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_out_q;
  logic               req_q;
  logic               valid_q;
  logic               fetch_done;
  logic               issue_done;

  // req_q and valid_q are registered copies of "next state is FETCH/ISSUE";
  // qualifying with them keeps acks in the first cycle after reset (req still
  // low) and acks outside FETCH from having any effect.
  assign fetch_done = (state == ST_FETCH) && req_q && bus.imem_ack;
  assign issue_done = (state == ST_ISSUE) && valid_q && bus.issue_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_FETCH: begin
        if (fetch_done) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_done) begin
          // ni/branch_target only matter on this handshake edge.
          pc_nxt = bus.ni ? bus.branch_target : pc + PC_ONE;
`ifdef FETCH_HALT_EN
          state_nxt = (instr_q[INSTR_W-1 -: OPCODE_W] == OPCODE_HALT) ? ST_HALT : ST_FETCH;
`else
          state_nxt = ST_FETCH;
`endif
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_q   <= (state_nxt == ST_FETCH);
      valid_q <= (state_nxt == ST_ISSUE);
      if (fetch_done) begin
        instr_q  <= bus.imem_rdata;
        pc_out_q <= pc;
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.issue_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.opCode      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign bus.pc_out      = pc_out_q;

`ifdef FETCH_HALT_EN
  assign halted = (state == ST_HALT);
`endif

  // Flags are registered, so a controlUnit computing ni on the same edge as a
  // flag write still sees the old values.
  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (alu_flag_we),
    .n_in  (alu_n),
    .z_in  (alu_z),
    .n_q   (flagN),
    .z_q   (flagZ)
  );

endmodule

// File: tb/tb_fetch_issue.sv
// tb_fetch_issue: directed + randomized bench for fetch_issue.
// A transaction-level model tracks the expected PC, the latched instruction
// and the N/Z flags; the DUT is compared against it after every clock edge.
module tb_fetch_issue;

  logic clk;
  logic rst_n;
  logic flagN, flagZ;
  logic alu_flag_we, alu_n, alu_z;
`ifdef FETCH_HALT_EN
  logic halted;
`endif

  fetch_issue_if #(.PC_W(16), .INSTR_W(32)) bus ();

  fetch_issue #(
    .PC_W     (16),
    .INSTR_W  (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flagN       (flagN),
    .flagZ       (flagZ),
    .alu_flag_we (alu_flag_we),
    .alu_n       (alu_n),
    .alu_z       (alu_z)
`ifdef FETCH_HALT_EN
    ,
    .halted      (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state
  logic [15:0] mpc;
  logic [15:0] mpcOut;
  logic [31:0] minstr;
  logic        mflagN, mflagZ;
  bit          aluRand;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the flag model follows whatever was driven into the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mflagN = 1'b0;
      mflagZ = 1'b0;
    end else if (alu_flag_we) begin
      mflagN = alu_n;
      mflagZ = alu_z;
    end
    #1;
    checkOutput("flagN", {31'd0, flagN}, {31'd0, mflagN});
    checkOutput("flagZ", {31'd0, flagZ}, {31'd0, mflagZ});
  endtask

  task automatic randAlu();
    if (aluRand) begin
      alu_flag_we = ($urandom_range(0, 2) == 0);
      alu_n       = 1'($urandom_range(0, 1));
      alu_z       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic checkIssueHold();
    checkOutput("issue_valid", {31'd0, bus.issue_valid}, 32'd1);
    checkOutput("req_low_in_issue", {31'd0, bus.imem_req}, 32'd0);
    checkOutput("instr_out", bus.instr_out, minstr);
    checkOutput("pc_out", {16'd0, bus.pc_out}, {16'd0, mpcOut});
    checkOutput("opCode", {28'd0, bus.opCode}, {28'd0, minstr[31:28]});
  endtask

  // Fetch one word: wait (bounded) for the request, hold ack low for
  // 'delay' cycles, then ack with 'data'.
  task automatic applyStimulus(input logic [31:0] data, input int delay);
    for (int i = 0; i < 10 && !bus.imem_req; i++) tick();
    checkOutput("req_up", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("fetch_addr", {16'd0, bus.imem_addr}, {16'd0, mpc});
    checkOutput("no_valid_in_fetch", {31'd0, bus.issue_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack = 1'b0;
      randAlu();
      tick();
      checkOutput("req_held", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("addr_held", {16'd0, bus.imem_addr}, {16'd0, mpc});
      checkOutput("valid_low_wait", {31'd0, bus.issue_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    randAlu();
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    minstr = data;
    mpcOut = mpc;
    checkIssueHold();
  endtask

  // Hold the issued word for 'stall' cycles (with ack/ni noise that must be
  // ignored), then hand it over with the given ni/target and flag write.
  task automatic issueTxn(input int stall, input logic niv, input logic [15:0] tgt,
                          input logic we, input logic n, input logic z);
    for (int i = 0; i < stall; i++) begin
      bus.issue_ready   = 1'b0;
      bus.imem_ack      = 1'($urandom_range(0, 1));
      bus.imem_rdata    = $urandom;
      bus.ni            = 1'($urandom_range(0, 1));
      bus.branch_target = 16'($urandom);
      randAlu();
      tick();
      checkIssueHold();
    end
    bus.imem_ack      = 1'b0;
    bus.issue_ready   = 1'b1;
    bus.ni            = niv;
    bus.branch_target = tgt;
    alu_flag_we       = we;
    alu_n             = n;
    alu_z             = z;
    tick();
    bus.issue_ready = 1'b0;
    bus.ni          = 1'b0;
    mpc = niv ? tgt : mpc + 16'd1;
    checkOutput("valid_drop", {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("req_rise", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("next_addr", {16'd0, bus.imem_addr}, {16'd0, mpc});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, bus.issue_valid}, 32'd0);
    checkOutput({tag, "_instr"}, bus.instr_out, 32'd0);
    checkOutput({tag, "_pc_out"}, {16'd0, bus.pc_out}, 32'd0);
    checkOutput({tag, "_addr"}, {16'd0, bus.imem_addr}, 32'd0);
    checkOutput({tag, "_flagN"}, {31'd0, flagN}, 32'd0);
    checkOutput({tag, "_flagZ"}, {31'd0, flagZ}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n             = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.issue_ready   = 1'b0;
    bus.ni            = 1'b0;
    bus.branch_target = '0;
    alu_flag_we       = 1'b0;
    alu_n             = 1'b0;
    alu_z             = 1'b0;
    aluRand           = 1'b1;
    mflagN            = 1'b0;
    mflagZ            = 1'b0;
    mpc               = 16'h0000;
    mpcOut            = 16'h0000;
    minstr            = '0;

    $display("[TB] reset");
    repeat (2) tick();
    checkResetState("reset");
    rst_n = 1'b1;
    tick();
    checkOutput("req_after_release", {31'd0, bus.imem_req}, 32'd1);

    $display("[TB] first fetch, ack after 2 cycles");
    applyStimulus(32'h0000_0001, 2);

    $display("[TB] 5-cycle issue stall, sequential next");
    issueTxn(5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] taken branch");
    applyStimulus(32'h1234_5678, 0);
    issueTxn(0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);

    $display("[TB] PC wrap");
    applyStimulus(32'h2000_0000, 0);
    issueTxn(1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h3000_0000, 1);
    issueTxn(0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    $display("[TB] flag write on handshake edge");
    aluRand     = 1'b0;
    alu_flag_we = 1'b1;
    alu_n       = 1'b0;
    alu_z       = 1'b0;
    applyStimulus(32'h4000_0000, 1);
    issueTxn(0, mflagZ, 16'h1234, 1'b1, 1'b0, 1'b1);
    checkOutput("flagZ_new", {31'd0, flagZ}, 32'd1);
    alu_flag_we = 1'b0;
    aluRand     = 1'b1;

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      d = $urandom;
`ifdef FETCH_HALT_EN
      if (d[31:28] == 4'hF) d[31] = 1'b0;
`endif
      applyStimulus(d, $urandom_range(0, 3));
      issueTxn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset in the middle of ISSUE");
    applyStimulus(32'hABCD_0123, 0);
    #3;
    rst_n = 1'b0;
    #1;
    mflagN = 1'b0;
    mflagZ = 1'b0;
    mpc    = 16'h0000;
    checkResetState("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("req_after_midreset", {31'd0, bus.imem_req}, 32'd1);
    applyStimulus(32'h0BAD_F00D, 1);
    issueTxn(2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef FETCH_HALT_EN
    $display("[TB] HALT opcode");
    applyStimulus(32'hF000_0000, 0);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    checkOutput("halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_valid", {31'd0, bus.issue_valid}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      randAlu();
      tick();
      checkOutput("halt_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("halt_hold", {31'd0, halted}, 32'd1);
    end
    bus.imem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mpc = 16'h0000;
    checkOutput("halt_cleared", {31'd0, halted}, 32'd0);
    checkOutput("halt_restart_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("halt_restart_addr", {16'd0, bus.imem_addr}, {16'd0, mpc});
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width in bits; opcode field = instr[INSTR_W-1 -: 4].
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state updates on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  imem_req  out  1  instruction-memory read request.
  imem_addr  out  PC_W  read address (current PC).
  imem_ack  in  1  read data valid this cycle.
  imem_rdata  in  INSTR_W  instruction word.
  issue_valid  out  1  instruction presented to controlUnit/datapath.
  issue_ready  in  1  consumer accepts the issued instruction.
  instr_out  out  INSTR_W  latched instruction.
  opCode  out  4  opcode field of instr_out, feeds controlUnit.opCode.
  flagN, flagZ  out  1 each  registered flags, feed controlUnit.flagN/flagZ.
  alu_flag_we  in  1  ALU flag update strobe.
  alu_n, alu_z  in  1 each  new flag values.
  ni  in  1  taken-branch indication from controlUnit.
  branch_target  in  PC_W  next PC when ni=1.
  pc_out  out  PC_W  PC of instr_out.
  halted  out  1  fetch stopped (only with FETCH_HALT_EN).

Function
REQ-005 SHALL implement FSM states FETCH, ISSUE, HALT; reset state FETCH.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC, held stable until imem_ack.
REQ-007 On imem_ack in FETCH, SHALL latch imem_rdata into instr_out, PC into pc_out, and enter ISSUE next cycle; imem_req drops same edge.
REQ-008 Latency: imem_ack at cycle t SHALL give issue_valid=1 at cycle t+1.
REQ-009 In ISSUE, issue_valid SHALL be 1 and instr_out/opCode/pc_out SHALL stay stable until issue_ready=1.
REQ-010 On issue_valid&issue_ready: PC SHALL load branch_target if ni=1, else PC+1 modulo 2^PC_W; state returns to FETCH.
REQ-011 PC increment SHALL wrap: all-ones -> 0, no flag or error raised.
REQ-012 ni and branch_target SHALL be sampled only on the issue handshake edge; ignored otherwise.
REQ-013 flagN/flagZ SHALL load alu_n/alu_z on any edge with alu_flag_we=1, independent of FSM state.
REQ-014 When alu_flag_we coincides with an issue handshake, ni SHALL reflect pre-update flags; new flags visible from next cycle.
REQ-015 imem_req and issue_valid SHALL never be 1 in the same cycle.
REQ-016 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-017 While rst_n=0, asynchronously: state=FETCH, PC=RESET_PC, instr_out=0, pc_out=0, flagN=0, flagZ=0, halted=0, issue_valid=0.
REQ-018 imem_req SHALL be 0 while rst_n=0 and rise the first edge after release.
REQ-019 Reset mid-FETCH or mid-ISSUE SHALL abandon the transaction; pending instruction discarded.

Configuration
REQ-020 Macro FETCH_HALT_EN defined: opcode 4'b1111 accepted via issue handshake SHALL enter HALT; HALT keeps imem_req=0, issue_valid=0, halted=1 until reset; flags still update.
REQ-021 Macro undefined: HALT state and halted port absent; 4'b1111 treated as ordinary instruction.

Structure
REQ-022 Shared package cpu_pkg SHALL hold the fetch state enum, OPCODE_HALT constant, and opcode-field width.
REQ-023 Sub-module flag_reg (NZ register with write enable) SHALL be instantiated; rest is a single module.

Verification
REQ-024 Reset release, imem_ack after 2 cycles with 0x0000_0001 -> imem_addr=0, issue_valid one cycle after ack, opCode=0000, pc_out=0.
REQ-025 issue_ready held 0 for 5 cycles -> instr_out stable, no new imem_req; ready=1, ni=0 -> next imem_addr=1.
REQ-026 Issue with ni=1, branch_target=0x0040 -> next imem_addr=0x0040.
REQ-027 PC=0xFFFF, ni=0 handshake -> next imem_addr=0x0000.
REQ-028 alu_flag_we=1, alu_z=1 on handshake edge with opcode 0100 -> ni computed from old flagZ=0; flagZ=1 next cycle.
REQ-029 FETCH_HALT_EN, issue 0xF000_0000 -> halted=1, imem_req stays 0 for 20 cycles; rst_n pulse -> imem_addr=RESET_PC.
